// File: rtl/x1_prog_loader_if.sv
// rtl/x1_prog_loader_if.sv - load-stream handshake between an upstream word source and the program loader
//
// Signals:
//   in_valid  upstream word valid (master drives)
//   in_data   upstream word, DW bits (master drives)
//   in_ready  loader accepts in_data this cycle (slave drives)
// A word moves on a rising edge where in_valid and in_ready are both high.
interface x1_prog_loader_if #(
   parameter int DW = 16
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/x1_prog_loader.sv
// rtl/x1_prog_loader.sv - streams a program image into local memory, then releases the CPU
//
// Ports:
//   cpuClk     single clock, rising edge
//   cpuRst     asynchronous active-high reset
//   start      one-cycle request to begin a load (honoured in IDLE, DONE and ERR only)
//   len        words to load minus one, latched on an accepted start
//   ld         load stream (slave side): in_valid / in_data / in_ready
//   rd_addr    CPU fetch address
//   rd_data    mem[rd_addr], one cycle latency, old data on a same-cycle write
//   load_busy  high while words are being taken (LOAD, and CHK when present)
//   cpu_run    high in DONE; releases the downstream CPU
//   load_err   checksum mismatch flag (constant 0 without the checksum build)
//   wcount     words written in the current or last load
//
// Build option: define X1_LOAD_CHECKSUM_EN to append a checksum word after
// the program. The loader sums the loaded words modulo 2^DW, takes one extra
// word in CHK (never written to memory) and goes to DONE on a match or ERR
// otherwise.
module x1_prog_loader #(
   parameter  int DW    = 16,
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic            cpuClk,
   input  logic            cpuRst,
   input  logic            start,
   input  logic [AW-1:0]   len,
   x1_prog_loader_if.slave ld,
   input  logic [AW-1:0]   rd_addr,
   output logic [DW-1:0]   rd_data,
   output logic            load_busy,
   output logic            cpu_run,
   output logic            load_err,
   output logic [AW:0]     wcount
);

`ifdef X1_LOAD_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, CHK, DONE, ERR} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

   state_t        state;
   logic [AW-1:0] addr;
   logic [AW-1:0] len_q;
   logic [DW-1:0] mem [DEPTH];
   logic          wr_en;

   // Only LOAD writes memory; the checksum word taken in CHK never does.
   assign wr_en = (state == LOAD) && ld.in_valid && ld.in_ready;

`ifdef X1_LOAD_CHECKSUM_EN
   logic [DW-1:0] sum;
`else
   assign load_err = 1'b0;
`endif

   always_ff @(posedge cpuClk or posedge cpuRst) begin
      if (cpuRst) begin
         state       <= IDLE;
         ld.in_ready <= 1'b0;
         load_busy   <= 1'b0;
         cpu_run     <= 1'b0;
         wcount      <= '0;
         addr        <= '0;
         len_q       <= '0;
`ifdef X1_LOAD_CHECKSUM_EN
         load_err    <= 1'b0;
         sum         <= '0;
`endif
      end else begin
         case (state)
`ifdef X1_LOAD_CHECKSUM_EN
            IDLE, DONE, ERR: begin
`else
            IDLE, DONE: begin
`endif
               if (start) begin
                  state       <= LOAD;
                  len_q       <= len;
                  addr        <= '0;
                  wcount      <= '0;
                  ld.in_ready <= 1'b1;
                  load_busy   <= 1'b1;
                  cpu_run     <= 1'b0;
`ifdef X1_LOAD_CHECKSUM_EN
                  load_err    <= 1'b0;
                  sum         <= '0;
`endif
               end
            end
            LOAD: begin
               if (wr_en) begin
                  wcount <= wcount + (AW+1)'(1);
`ifdef X1_LOAD_CHECKSUM_EN
                  sum    <= sum + ld.in_data;
`endif
                  // addr parks on the last word so a full-depth load never wraps.
                  if (addr == len_q) begin
`ifdef X1_LOAD_CHECKSUM_EN
                     state       <= CHK;
`else
                     state       <= DONE;
                     ld.in_ready <= 1'b0;
                     load_busy   <= 1'b0;
                     cpu_run     <= 1'b1;
`endif
                  end else begin
                     addr <= addr + AW'(1);
                  end
               end
            end
`ifdef X1_LOAD_CHECKSUM_EN
            CHK: begin
               if (ld.in_valid && ld.in_ready) begin
                  ld.in_ready <= 1'b0;
                  load_busy   <= 1'b0;
                  if (ld.in_data == sum) begin
                     state   <= DONE;
                     cpu_run <= 1'b1;
                  end else begin
                     state    <= ERR;
                     load_err <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state       <= IDLE;
               ld.in_ready <= 1'b0;
               load_busy   <= 1'b0;
               cpu_run     <= 1'b0;
            end
         endcase
      end
   end

   // Program memory keeps its contents through reset.
   always_ff @(posedge cpuClk) begin
      if (wr_en)
         mem[addr] <= ld.in_data;
   end

   // Reads sample the pre-write contents, giving read-before-write on a collision.
   always_ff @(posedge cpuClk or posedge cpuRst) begin
      if (cpuRst)
         rd_data <= '0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule
